fir_decim_mc: RTL

- Multi-channel, decimating FIR filter with runtime-loadable coefficients, rounding and output saturation.
- Sits between an input sample FIFO and an output FIFO in the FM demod chain, for example the stereo L/R path.
- All channels share one coefficient set and are filtered in lock-step, one tap per cycle per channel.
- Produces one output word per DECIMATION input words.

---
 rtl/fir_decim_mc.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fir_decim_mc.sv
// fir_decim_mc: multi-channel decimating FIR, lock-step MAC per channel,
// runtime coefficients, round-half-up and saturation on output.
`timescale 1ns/1ps
module fir_decim_mc #(
   parameter int DATA_WIDTH  = 32,
   parameter int COEFF_WIDTH = 32,
   parameter int TAPS        = 32,
   parameter int DECIMATION  = 8,
   parameter int CHANNELS    = 2,
   parameter int QUANT_BITS  = 10
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [CHANNELS*DATA_WIDTH-1:0] x_in,
   input  logic                           x_empty,
   output logic                           x_rd_en,
   output logic [CHANNELS*DATA_WIDTH-1:0] y_out,
   input  logic                           y_out_full,
   output logic                           y_wr_en,
   output logic [CHANNELS-1:0]            y_sat,
   input  logic                           coeff_wr_en,
   input  logic [$clog2(TAPS)-1:0]        coeff_addr,
   input  logic [COEFF_WIDTH-1:0]         coeff_data,
   output logic                           coeff_ready
);

   localparam int AW    = $clog2(TAPS);
   localparam int CW    = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
   localparam int PW    = DATA_WIDTH + COEFF_WIDTH;
   localparam int ACC_W = PW + $clog2(TAPS);

   localparam logic signed [COEFF_WIDTH-1:0] H_ONE =
      {{(COEFF_WIDTH-1){1'b0}}, 1'b1} << QUANT_BITS;
   localparam logic signed [ACC_W-1:0] RND =
      {{(ACC_W-1){1'b0}}, 1'b1} << (QUANT_BITS-1);
   localparam logic signed [DATA_WIDTH-1:0] DMAX =
      {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] DMIN =
      {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] YMAX =
      {{(ACC_W-DATA_WIDTH){1'b0}}, DMAX};
   localparam logic signed [ACC_W-1:0] YMIN =
      {{(ACC_W-DATA_WIDTH){1'b1}}, DMIN};

   typedef enum logic [1:0] {
      LOAD,
      MAC,
      OUT
   } state_t;

   state_t          state;
   logic [CW-1:0]   count;
   logic [AW-1:0]   k;
   logic            last_word;
   logic            last_tap;
   logic            coeff_we;

   logic signed [DATA_WIDTH-1:0]  dly [CHANNELS][TAPS];
   logic signed [COEFF_WIDTH-1:0] h [TAPS];
   logic signed [ACC_W-1:0]       acc [CHANNELS];
   logic signed [ACC_W-1:0]       sum [CHANNELS];
   logic signed [DATA_WIDTH-1:0]  res [CHANNELS];
   logic                          clip [CHANNELS];

   assign x_rd_en     = (state == LOAD) && !x_empty;
   assign y_wr_en     = (state == OUT) && !y_out_full;
   assign coeff_ready = (state != MAC);
   assign last_word   = (32'(count) == DECIMATION - 1);
   assign last_tap    = (32'(k) == TAPS - 1);
   assign coeff_we    = coeff_ready && coeff_wr_en &&
                        (32'(coeff_addr) < TAPS);

   // Current tap product folded into each accumulator, then rounded and
   // clamped so the final MAC cycle can latch results directly.
   always_comb begin : mac_path
      logic signed [PW-1:0]    hx;
      logic signed [PW-1:0]    dx;
      logic signed [PW-1:0]    prod;
      logic signed [ACC_W-1:0] rnd;
      logic signed [ACC_W-1:0] r;
      hx   = '0;
      dx   = '0;
      prod = '0;
      rnd  = '0;
      r    = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         hx   = {{DATA_WIDTH{h[k][COEFF_WIDTH-1]}}, h[k]};
         dx   = {{COEFF_WIDTH{dly[c][k][DATA_WIDTH-1]}}, dly[c][k]};
         prod = hx * dx;
         sum[c] = acc[c] + {{(ACC_W-PW){prod[PW-1]}}, prod};
         rnd  = sum[c] + RND;
         r    = rnd >>> QUANT_BITS;
         if (r > YMAX) begin
            res[c]  = DMAX;
            clip[c] = 1'b1;
         end else if (r < YMIN) begin
            res[c]  = DMIN;
            clip[c] = 1'b1;
         end else begin
            res[c]  = r[DATA_WIDTH-1:0];
            clip[c] = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= LOAD;
         count <= '0;
         k     <= '0;
         y_out <= '0;
         y_sat <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            acc[c] <= '0;
            for (int t = 0; t < TAPS; t++) begin
               dly[c][t] <= '0;
            end
         end
      end else begin
         unique case (state)
            LOAD: begin
               if (!x_empty) begin
                  for (int c = 0; c < CHANNELS; c++) begin
                     dly[c][0] <= x_in[c*DATA_WIDTH +: DATA_WIDTH];
                     for (int t = 1; t < TAPS; t++) begin
                        dly[c][t] <= dly[c][t-1];
                     end
                  end
                  if (last_word) begin
                     count <= '0;
                     k     <= '0;
                     state <= MAC;
                     for (int c = 0; c < CHANNELS; c++) begin
                        acc[c] <= '0;
                     end
                  end else begin
                     count <= count + CW'(1);
                  end
               end
            end
            MAC: begin
               for (int c = 0; c < CHANNELS; c++) begin
                  acc[c] <= sum[c];
               end
               if (last_tap) begin
                  for (int c = 0; c < CHANNELS; c++) begin
                     y_out[c*DATA_WIDTH +: DATA_WIDTH] <= res[c];
                     y_sat[c] <= clip[c];
                  end
                  state <= OUT;
               end else begin
                  k <= k + AW'(1);
               end
            end
            OUT: begin
               if (!y_out_full) begin
                  state <= LOAD;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   // Reset restores an identity filter on the newest sample.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int t = 0; t < TAPS; t++) begin
            h[t] <= '0;
         end
         h[0] <= H_ONE;
      end else if (coeff_we) begin
         h[coeff_addr] <= coeff_data;
      end
   end

endmodule
